screen_sequencer: RTL and testbench

- Game-flow controller that drives the `current_screen` and `countdown` inputs of the `screens` LED compositor.
- Sequence: menu idle, then menu countdown once players are ready, then gameplay, then finished hold, then back to menu.
- Detects the race winner from the four player positions.
- Issues a one-cycle `game_reset` pulse so the position/ready logic clears for the next round.

---
 rtl/game_pkg.sv | 23 ++
 rtl/screen_sequencer_if.sv | 34 +++
 rtl/sec_tick_gen.sv | 27 ++
 rtl/screen_sequencer.sv | 129 ++++++++++++
 tb/tb_screen_sequencer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared encodings for the game-flow logic: screen codes, player slots and
// the screen sequencer state type.
package game_pkg;

    localparam logic [1:0] SCREEN_MENU     = 2'b00;
    localparam logic [1:0] SCREEN_GAMEPLAY = 2'b01;
    localparam logic [1:0] SCREEN_FINISHED = 2'b10;

    // Slot order doubles as tie-break priority and as the winner bit position
    localparam int PLAYER_GREEN  = 0;
    localparam int PLAYER_RED    = 1;
    localparam int PLAYER_BLUE   = 2;
    localparam int PLAYER_YELLOW = 3;
    localparam int NUM_PLAYERS   = 4;

    typedef enum logic [1:0] {
        MENU_IDLE,
        MENU_COUNTDOWN,
        GAMEPLAY,
        FINISHED
    } seq_state_t;

endpackage

// File: rtl/screen_sequencer_if.sv
// Player-side inputs and compositor-side outputs of the screen sequencer.
interface screen_sequencer_if #(
    parameter int MAX_POS = 109
);
    localparam int POS_W = $clog2(MAX_POS);

    logic             green_ready_to_play;
    logic             red_ready_to_play;
    logic             blue_ready_to_play;
    logic             yellow_ready_to_play;
    logic [POS_W-1:0] green_cur_pos;
    logic [POS_W-1:0] red_cur_pos;
    logic [POS_W-1:0] blue_cur_pos;
    logic [POS_W-1:0] yellow_cur_pos;
    logic [1:0]       current_screen;
    logic [2:0]       countdown;
    logic [3:0]       winner;
    logic             game_reset;

    modport master (
        output green_ready_to_play, red_ready_to_play,
               blue_ready_to_play, yellow_ready_to_play,
        output green_cur_pos, red_cur_pos, blue_cur_pos, yellow_cur_pos,
        input  current_screen, countdown, winner, game_reset
    );

    modport slave (
        input  green_ready_to_play, red_ready_to_play,
               blue_ready_to_play, yellow_ready_to_play,
        input  green_cur_pos, red_cur_pos, blue_cur_pos, yellow_cur_pos,
        output current_screen, countdown, winner, game_reset
    );

endinterface

// File: rtl/sec_tick_gen.sv
// One-cycle pulse every TICKS_PER_SEC clocks; clear restarts a full second.
module sec_tick_gen #(
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic sec_tick
);
    localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] tick_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            tick_cnt <= '0;
        end else if (tick_cnt == LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign sec_tick = (tick_cnt == LAST);

endmodule

// File: rtl/screen_sequencer.sv
// Game-flow controller: menu, countdown, gameplay and finished-hold screens,
// winner detection and the end-of-round game_reset pulse.
module screen_sequencer
    import game_pkg::*;
#(
    parameter int MAX_POS         = 109,
    parameter int TICKS_PER_SEC   = 50000000,
    parameter int COUNTDOWN_START = 5,
    parameter int END_HOLD_SEC    = 10
) (
    input  logic               clk,
    input  logic               rst,
    screen_sequencer_if.slave  bus
);
    localparam int POS_W = $clog2(MAX_POS);
    localparam int HOLD_W = $clog2(END_HOLD_SEC + 1);
    localparam logic [POS_W-1:0]  FINISH_POS = POS_W'(MAX_POS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(END_HOLD_SEC - 1);
    localparam logic [2:0]        CD_START   = 3'(COUNTDOWN_START);

    seq_state_t        state;
    logic [1:0]        screen_q;
    logic [2:0]        countdown_q;
    logic [3:0]        winner_q;
    logic              game_reset_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [3:0]        winner_next;
    logic [POS_W-1:0]  pos [NUM_PLAYERS];
    logic              any_ready;
    logic              sec_tick;
    logic              tick_clear;

    assign pos[PLAYER_GREEN]  = bus.green_cur_pos;
    assign pos[PLAYER_RED]    = bus.red_cur_pos;
    assign pos[PLAYER_BLUE]   = bus.blue_cur_pos;
    assign pos[PLAYER_YELLOW] = bus.yellow_cur_pos;

    assign any_ready = bus.green_ready_to_play | bus.red_ready_to_play |
                       bus.blue_ready_to_play | bus.yellow_ready_to_play;

    // Untimed states hold the tick counter at zero, so every timed state starts on a full second
    assign tick_clear = (state == MENU_IDLE) || (state == GAMEPLAY);

    sec_tick_gen #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_sec_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (tick_clear),
        .sec_tick (sec_tick)
    );

    // Scanning from the lowest-priority slot lets green overwrite every other finisher
    always_comb begin
        winner_next = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (pos[i] >= FINISH_POS) begin
                winner_next = 4'b0001 << i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= MENU_IDLE;
            screen_q     <= SCREEN_MENU;
            countdown_q  <= '0;
            winner_q     <= '0;
            game_reset_q <= 1'b0;
            hold_cnt     <= '0;
        end else begin
            game_reset_q <= 1'b0;
            case (state)
                MENU_IDLE: begin
                    if (any_ready) begin
                        state       <= MENU_COUNTDOWN;
                        countdown_q <= CD_START;
                    end
                end
                MENU_COUNTDOWN: begin
                    if (!any_ready) begin
                        state       <= MENU_IDLE;
                        countdown_q <= '0;
                    end else if (sec_tick) begin
                        if (countdown_q > 3'd1) begin
                            countdown_q <= countdown_q - 3'd1;
                        end else begin
                            state       <= GAMEPLAY;
                            screen_q    <= SCREEN_GAMEPLAY;
                            countdown_q <= '0;
                        end
                    end
                end
                GAMEPLAY: begin
                    if (|winner_next) begin
                        state    <= FINISHED;
                        screen_q <= SCREEN_FINISHED;
                        winner_q <= winner_next;
                        hold_cnt <= '0;
                    end
                end
                FINISHED: begin
                    // The pulse cycle is the last cycle on the finished screen
                    if (game_reset_q) begin
                        state    <= MENU_IDLE;
                        screen_q <= SCREEN_MENU;
                        winner_q <= '0;
                    end else if (sec_tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            game_reset_q <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= MENU_IDLE;
                    screen_q <= SCREEN_MENU;
                end
            endcase
        end
    end

    assign bus.current_screen = screen_q;
    assign bus.countdown      = countdown_q;
    assign bus.winner         = winner_q;
    assign bus.game_reset     = game_reset_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer with a cycle-age reference model checked every cycle.
module tb_screen_sequencer;

    localparam int MAX_POS = 109;
    localparam int TICKS   = 4;
    localparam int CD_ST   = 3;
    localparam int HOLD    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ready [4];
    logic [6:0] pos [4];
    bit         compare_en = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;

    // Model: phase 0 menu idle, 1 countdown, 2 gameplay, 3 finished; age = cycles in phase
    int         m_phase = 0;
    int         m_age = 0;
    logic [3:0] m_win = '0;

    always #5 clk = ~clk;

    screen_sequencer_if #(.MAX_POS(MAX_POS)) bus ();

    assign bus.green_ready_to_play  = ready[0];
    assign bus.red_ready_to_play    = ready[1];
    assign bus.blue_ready_to_play   = ready[2];
    assign bus.yellow_ready_to_play = ready[3];
    assign bus.green_cur_pos        = pos[0];
    assign bus.red_cur_pos          = pos[1];
    assign bus.blue_cur_pos         = pos[2];
    assign bus.yellow_cur_pos       = pos[3];

    screen_sequencer #(
        .MAX_POS         (MAX_POS),
        .TICKS_PER_SEC   (TICKS),
        .COUNTDOWN_START (CD_ST),
        .END_HOLD_SEC    (HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic int first_finisher();
        for (int i = 0; i < 4; i++) begin
            if (int'(pos[i]) >= MAX_POS - 1) return i;
        end
        return -1;
    endfunction

    function automatic logic [1:0] exp_screen();
        return (m_phase == 2) ? 2'b01 : (m_phase == 3) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [2:0] exp_countdown();
        return (m_phase == 1) ? 3'(CD_ST - m_age / TICKS) : 3'd0;
    endfunction

    function automatic logic [3:0] exp_winner();
        return (m_phase == 3) ? m_win : 4'b0000;
    endfunction

    function automatic logic exp_game_reset();
        return (m_phase == 3) && (m_age == HOLD * TICKS);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_age   <= 0;
            m_win   <= '0;
        end else begin
            case (m_phase)
                0: if (ready[0] | ready[1] | ready[2] | ready[3]) begin
                    m_phase <= 1;
                    m_age   <= 0;
                end
                1: if (!(ready[0] | ready[1] | ready[2] | ready[3])) begin
                    m_phase <= 0;
                    m_age   <= 0;
                end else if (m_age + 1 == CD_ST * TICKS) begin
                    m_phase <= 2;
                    m_age   <= 0;
                end else begin
                    m_age <= m_age + 1;
                end
                2: if (first_finisher() >= 0) begin
                    m_phase <= 3;
                    m_age   <= 0;
                    m_win   <= 4'(1 << first_finisher());
                end
                default: if (m_age == HOLD * TICKS) begin
                    m_phase <= 0;
                    m_age   <= 0;
                    m_win   <= '0;
                end else begin
                    m_age <= m_age + 1;
                end
            endcase
        end
    end

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (compare_en) begin
            cmp("screen", 8'(bus.current_screen), 8'(exp_screen()));
            cmp("countdown", 8'(bus.countdown), 8'(exp_countdown()));
            cmp("winner", 8'(bus.winner), 8'(exp_winner()));
            cmp("game_reset", 8'(bus.game_reset), 8'(exp_game_reset()));
        end
    end

    // Hand-computed expectations, checked against both the DUT and the model
    task automatic check_output(input string tag, input logic [1:0] scr, input logic [2:0] cd,
                                input logic [3:0] win, input logic gr);
        cmp({tag, ".screen"}, 8'(bus.current_screen), 8'(scr));
        cmp({tag, ".countdown"}, 8'(bus.countdown), 8'(cd));
        cmp({tag, ".winner"}, 8'(bus.winner), 8'(win));
        cmp({tag, ".game_reset"}, 8'(bus.game_reset), 8'(gr));
        cmp({tag, ".model_screen"}, 8'(exp_screen()), 8'(scr));
        cmp({tag, ".model_countdown"}, 8'(exp_countdown()), 8'(cd));
        cmp({tag, ".model_winner"}, 8'(exp_winner()), 8'(win));
        cmp({tag, ".model_game_reset"}, 8'(exp_game_reset()), 8'(gr));
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic [3:0] rdy, input logic [6:0] p0, input logic [6:0] p1,
                                  input logic [6:0] p2, input logic [6:0] p3);
        for (int i = 0; i < 4; i++) ready[i] = rdy[i];
        pos[0] = p0;
        pos[1] = p1;
        pos[2] = p2;
        pos[3] = p3;
    endtask

    initial begin
        apply_stimulus(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
        rst = 1'b1;
        step(2);
        compare_en = 1'b1;
        rst = 1'b0;

        step(1);
        check_output("reset_release", 2'b00, 3'd0, 4'b0000, 1'b0);
        step(10);
        check_output("idle_hold", 2'b00, 3'd0, 4'b0000, 1'b0);

        apply_stimulus(4'b0010, 7'd0, 7'd0, 7'd0, 7'd0);
        step(1);
        check_output("cd_start", 2'b00, 3'd3, 4'b0000, 1'b0);
        step(4);
        check_output("cd_two", 2'b00, 3'd2, 4'b0000, 1'b0);
        step(4);
        check_output("cd_one", 2'b00, 3'd1, 4'b0000, 1'b0);
        step(4);
        check_output("gameplay", 2'b01, 3'd0, 4'b0000, 1'b0);

        apply_stimulus(4'b0010, 7'd50, 7'd0, 7'd108, 7'd108);
        step(1);
        check_output("tie_blue_yellow", 2'b10, 3'd0, 4'b0100, 1'b0);
        apply_stimulus(4'b0001, 7'd0, 7'd0, 7'd0, 7'd0);
        step(7);
        check_output("hold_f7", 2'b10, 3'd0, 4'b0100, 1'b0);
        step(1);
        check_output("game_reset_f8", 2'b10, 3'd0, 4'b0100, 1'b1);
        apply_stimulus(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
        step(1);
        check_output("back_to_menu_f9", 2'b00, 3'd0, 4'b0000, 1'b0);

        apply_stimulus(4'b0100, 7'd0, 7'd0, 7'd0, 7'd0);
        step(1);
        check_output("abort_cd_start", 2'b00, 3'd3, 4'b0000, 1'b0);
        step(4);
        apply_stimulus(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
        step(1);
        check_output("abort", 2'b00, 3'd0, 4'b0000, 1'b0);
        apply_stimulus(4'b0001, 7'd0, 7'd0, 7'd0, 7'd0);
        step(1);
        check_output("restart", 2'b00, 3'd3, 4'b0000, 1'b0);
        step(2);
        apply_stimulus(4'b1001, 7'd0, 7'd0, 7'd0, 7'd0);
        step(2);
        check_output("join_no_restart", 2'b00, 3'd2, 4'b0000, 1'b0);

        rst = 1'b1;
        step(1);
        check_output("rst_in_countdown", 2'b00, 3'd0, 4'b0000, 1'b0);
        rst = 1'b0;
        step(1);
        check_output("cd_after_rst", 2'b00, 3'd3, 4'b0000, 1'b0);
        step(12);
        check_output("gameplay_2", 2'b01, 3'd0, 4'b0000, 1'b0);
        apply_stimulus(4'b1001, 7'd0, 7'd115, 7'd107, 7'd0);
        step(1);
        check_output("beyond_finish_red", 2'b10, 3'd0, 4'b0010, 1'b0);
        step(3);
        rst = 1'b1;
        apply_stimulus(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
        step(1);
        check_output("rst_in_finished", 2'b00, 3'd0, 4'b0000, 1'b0);
        rst = 1'b0;
        step(2);
        check_output("idle_after_rst", 2'b00, 3'd0, 4'b0000, 1'b0);

        apply_stimulus(4'b1000, 7'd0, 7'd0, 7'd0, 7'd0);
        step(13);
        check_output("gameplay_3", 2'b01, 3'd0, 4'b0000, 1'b0);
        apply_stimulus(4'b1000, 7'd108, 7'd108, 7'd0, 7'd108);
        step(1);
        check_output("tie_green_first", 2'b10, 3'd0, 4'b0001, 1'b0);
        apply_stimulus(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
        step(9);
        check_output("final_menu", 2'b00, 3'd0, 4'b0000, 1'b0);
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
